// File: rtl/text_overlay_gen.sv
// Character-cell text renderer: text buffer with post-reset clear sweep, two-stage
// pixel pipeline driving the glyph ROM, and a frame-counted blinking cursor.
module text_overlay_gen #(
    parameter int unsigned COLS     = 80,
    parameter int unsigned ROWS     = 30,
    parameter logic [23:0] FG_RGB   = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB   = 24'h000000,
    parameter int unsigned BLINK_FR = 30
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic [11:0] wr_addr_i,
    input  logic [6:0]  wr_data_i,
    output logic        busy_o,
    input  logic [6:0]  cur_col_i,
    input  logic [4:0]  cur_row_i,
    input  logic        cur_en_i,
    input  logic        frame_i,
    input  logic        vid_valid_i,
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    output logic [10:0] rom_addr_o,
    input  logic [7:0]  rom_data_i,
    output logic [23:0] rgb_o,
    output logic        rgb_valid_o
);

    localparam int unsigned DEPTH = COLS * ROWS;
    localparam logic [12:0] DEPTH_W = 13'(DEPTH);
    localparam logic [12:0] LAST_W = 13'(DEPTH - 1);
    localparam int unsigned CNT_W = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FR - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]  state_q;
    logic [11:0] ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else if (state_q == ST_CLEAR) begin
            ptr_q <= ptr_q + 12'd1;
            if ({1'b0, ptr_q} == LAST_W) begin
                state_q <= ST_RUN;
            end
        end
    end

    assign busy_o = (state_q == ST_CLEAR);

    // The sweep owns the single write port until it completes.
    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [6:0]  mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr_i;
        mem_wdata = wr_data_i;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = 7'h20;
        end else begin
            mem_we = wr_en_i && ({1'b0, wr_addr_i} < DEPTH_W);
        end
    end

    logic [6:0] mem [0:DEPTH-1];

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Stage 0: cell lookup and per-pixel attributes.
    logic [6:0]  col;
    logic [5:0]  row;
    logic        in_grid;
    logic [12:0] idx;
    logic [11:0] rd_addr;
    logic        cur_hit;

    always_comb begin
        col     = x_i[9:3];
        row     = y_i[9:4];
        in_grid = (32'(col) < COLS) && (32'(row) < ROWS);
        idx     = 13'(row) * 13'(COLS) + 13'(col);
        rd_addr = in_grid ? idx[11:0] : 12'd0;
        cur_hit = cur_en_i && (col == cur_col_i) && (row == {1'b0, cur_row_i});
    end

    logic [CNT_W-1:0] blink_cnt_q;
    logic             blink_phase_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (frame_i) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    logic [6:0] code_q;
    logic       v1_q;
    logic       in_grid1_q;
    logic [3:0] yrow_q;
    logic [2:0] xbit_q;
    logic       inv_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            code_q     <= '0;
            v1_q       <= 1'b0;
            in_grid1_q <= 1'b0;
            yrow_q     <= '0;
            xbit_q     <= '0;
            inv_q      <= 1'b0;
        end else begin
            code_q     <= mem[rd_addr];
            v1_q       <= vid_valid_i;
            in_grid1_q <= in_grid && (state_q == ST_RUN);
            yrow_q     <= y_i[3:0];
            xbit_q     <= x_i[2:0];
            inv_q      <= cur_hit && blink_phase_q;
        end
    end

    // Stage 1: glyph bit select, bit 7 is the leftmost pixel of the cell.
    logic glyph_bit;

    assign rom_addr_o = {code_q, yrow_q};
    assign glyph_bit  = rom_data_i[3'd7 - xbit_q] ^ inv_q;

    logic [23:0] rgb_q;
    logic        rgb_valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            rgb_valid_q <= v1_q;
            if (v1_q) begin
                rgb_q <= (in_grid1_q && glyph_bit) ? FG_RGB : BG_RGB;
            end
        end
    end

    assign rgb_o       = rgb_q;
    assign rgb_valid_o = rgb_valid_q;

endmodule
